// File: rtl/tl_test_indicator_slave_pkg.sv
// tl_test_indicator_slave_pkg: TL-UL opcodes, register offsets and test-result magic values
package tl_test_indicator_slave_pkg;
    typedef enum logic [2:0] {
        PUT_FULL    = 3'd0,
        PUT_PARTIAL = 3'd1,
        GET         = 3'd4
    } a_op_e;
    typedef enum logic [2:0] {
        ACCESS_ACK      = 3'd0,
        ACCESS_ACK_DATA = 3'd1
    } d_op_e;
    localparam int STATUS_OFF = 'h000;
    localparam int CYCLES_OFF = 'h004;
    localparam logic [15:0] PASS_MAGIC = 16'h5555;
    localparam logic [15:0] FAIL_MAGIC = 16'h3333;
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] mask);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = mask[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/tl_rsp_queue.sv
// tl_rsp_queue: small FIFO holding D-channel responses in request order
module tl_rsp_queue #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_ok, pop_ok;
    assign in_ready  = cnt_q != CW'(DEPTH);
    assign out_valid = cnt_q != '0;
    assign out_data  = mem_q[rd_ptr_q];
    assign push_ok   = push & in_ready;
    assign pop_ok    = pop & out_valid;
    // next storage, pointers (wrapping at DEPTH) and occupancy
    always_comb begin
        mem_d = mem_q;
        if (push_ok) mem_d[wr_ptr_q] = push_data;
        wr_ptr_d = !push_ok ? wr_ptr_q : (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        rd_ptr_d = !pop_ok ? rd_ptr_q : (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        cnt_d    = cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
    // queue state; reset clears entries so the head reads as zero
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/tl_test_indicator_slave.sv
// tl_test_indicator_slave: TL-UL slave with STATUS/CYCLES registers and a sticky test pass/fail indicator
module tl_test_indicator_slave
    import tl_test_indicator_slave_pkg::*;
#(
    parameter int ADDR_W    = 15,
    parameter int SRC_W     = 2,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [2:0]        a_opcode,
    input  logic [2:0]        a_param,
    input  logic [1:0]        a_size,
    input  logic [SRC_W-1:0]  a_source,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [3:0]        a_mask,
    input  logic [31:0]       a_data,
    input  logic              a_corrupt,
    output logic              d_valid,
    input  logic              d_ready,
    output logic [2:0]        d_opcode,
    output logic [1:0]        d_size,
    output logic [SRC_W-1:0]  d_source,
    output logic [31:0]       d_data,
    output logic              d_denied,
    output logic              d_corrupt,
    output logic              test_done,
    output logic              test_pass,
    output logic [15:0]       test_code
);
    localparam int RW = 3 + 2 + SRC_W + 32 + 2;
    logic          alive_q, q_ready, a_fire;
    logic [31:0]   status_q, status_d, cycles_q, cycles_d, merged, rsp_data;
    logic          done_q, done_d, pass_q, pass_d;
    logic [15:0]   code_q, code_d;
    logic          is_status, is_cycles, is_get, is_put, denied, wr_en, rsp_corrupt;
    logic [2:0]    rsp_op;
    logic [RW-1:0] head;
    assign a_ready   = alive_q & q_ready;
    assign a_fire    = a_valid & a_ready;
    assign test_done = done_q;
    assign test_pass = pass_q;
    assign test_code = code_q;
    assign {d_opcode, d_size, d_source, d_data, d_denied, d_corrupt} = head;
    // request decode and response formation
    always_comb begin
        is_status   = a_address[ADDR_W-1:2] == (ADDR_W-2)'(STATUS_OFF >> 2);
        is_cycles   = a_address[ADDR_W-1:2] == (ADDR_W-2)'(CYCLES_OFF >> 2);
        is_get      = a_opcode == GET;
        is_put      = (a_opcode == PUT_FULL) || (a_opcode == PUT_PARTIAL);
        denied      = !((is_get && (is_status || is_cycles)) || (is_put && is_status && !a_corrupt));
        wr_en       = a_fire && is_put && is_status && !a_corrupt;
        merged      = byte_merge(status_q, a_data, a_mask);
        rsp_op      = is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
        rsp_data    = (is_get && !denied) ? (is_status ? status_q : cycles_q) : 32'd0;
        rsp_corrupt = denied && is_get;
    end
    // register updates; the first pass/fail write wins until reset
    always_comb begin
        cycles_d = cycles_q + 32'd1;
        status_d = wr_en ? merged : status_q;
        done_d   = done_q;
        pass_d   = pass_q;
        code_d   = code_q;
        if (wr_en && !done_q && merged[15:0] == PASS_MAGIC) begin
            done_d = 1'b1;
            pass_d = 1'b1;
            code_d = 16'd0;
        end else if (wr_en && !done_q && merged[15:0] == FAIL_MAGIC) begin
            done_d = 1'b1;
            pass_d = 1'b0;
            code_d = merged[31:16];
        end
    end
    // state registers; alive_q holds a_ready low until the first edge after reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alive_q  <= 1'b0;
            status_q <= '0;
            cycles_q <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            code_q   <= '0;
        end else begin
            alive_q  <= 1'b1;
            status_q <= status_d;
            cycles_q <= cycles_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            code_q   <= code_d;
        end
    end
    tl_rsp_queue #(.DEPTH(RSP_DEPTH), .W(RW)) u_q (
        .clock     (clock),
        .reset     (reset),
        .push      (a_fire),
        .push_data ({rsp_op, a_size, a_source, rsp_data, denied, rsp_corrupt}),
        .pop       (d_ready),
        .in_ready  (q_ready),
        .out_valid (d_valid),
        .out_data  (head)
    );
endmodule

// File: tb/tb_tl_test_indicator_slave.sv
// tb_tl_test_indicator_slave: directed scenario checks for the test indicator slave
module tb_tl_test_indicator_slave;
    logic        clock = 0, reset = 1;
    logic        a_valid = 0, a_ready, a_corrupt = 0;
    logic [2:0]  a_opcode = 0, a_param = 0;
    logic [1:0]  a_size = 0, a_source = 0;
    logic [14:0] a_address = 0;
    logic [3:0]  a_mask = 0;
    logic [31:0] a_data = 0;
    logic        d_valid, d_ready = 0, d_denied, d_corrupt;
    logic [2:0]  d_opcode;
    logic [1:0]  d_size, d_source;
    logic [31:0] d_data;
    logic        test_done, test_pass;
    logic [15:0] test_code;
    int          total = 0, bad = 0;
    logic [31:0] v1, v2;

    always #5 clock = ~clock;

    tl_test_indicator_slave dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data), .a_corrupt(a_corrupt),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
        .d_source(d_source), .d_data(d_data), .d_denied(d_denied), .d_corrupt(d_corrupt),
        .test_done(test_done), .test_pass(test_pass), .test_code(test_code)
    );

    task automatic send(input logic [2:0] op, input logic [14:0] addr, input logic [31:0] data,
                        input logic [3:0] mask, input logic [1:0] src, input logic cor);
        logic ok;
        ok = 0;
        @(negedge clock);
        a_valid = 1; a_opcode = op; a_address = addr; a_data = data; a_mask = mask;
        a_source = src; a_corrupt = cor; a_size = 2'd2;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (a_ready) begin
                @(posedge clock);
                #1;
                ok = 1;
            end else @(negedge clock);
        end
        a_valid = 0;
        a_corrupt = 0;
        if (!ok) begin
            total++; bad++;
            $display("FAIL send_timeout op=%0d addr=%h never accepted", op, addr);
        end
    endtask

    task automatic pop;
        @(negedge clock);
        d_ready = 1;
        @(posedge clock);
        #1;
        d_ready = 0;
    endtask

    task automatic do_reset;
        a_valid = 0; d_ready = 0; reset = 1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1;
        repeat (2) @(posedge clock);
        #1;
        total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL rst_a_ready got=%b exp=0", a_ready); end
        total++; if (d_valid !== 1'b0) begin bad++; $display("FAIL rst_d_valid got=%b exp=0", d_valid); end
        total++; if ({test_done, test_pass, test_code} !== 18'd0) begin bad++; $display("FAIL rst_ind got=%b%b%h exp=0", test_done, test_pass, test_code); end
        total++; if (d_data !== 32'd0) begin bad++; $display("FAIL rst_d_data got=%h exp=0", d_data); end
        @(negedge clock);
        reset = 0;
        @(posedge clock);
        #1;
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL rst_release_a_ready got=%b exp=1", a_ready); end
    endtask

    task automatic test_pass_write;
        send(3'd0, 15'h000, 32'h0000_5555, 4'hF, 2'd1, 1'b0);
        total++; if (d_valid !== 1'b1) begin bad++; $display("FAIL pass_d_valid got=%b exp=1", d_valid); end
        total++; if ({d_opcode, d_source, d_denied, d_corrupt} !== {3'd0, 2'd1, 1'b0, 1'b0}) begin bad++; $display("FAIL pass_rsp got op=%0d src=%0d den=%b cor=%b exp op=0 src=1 den=0 cor=0", d_opcode, d_source, d_denied, d_corrupt); end
        total++; if (d_size !== 2'd2) begin bad++; $display("FAIL pass_d_size got=%0d exp=2", d_size); end
        total++; if (d_data !== 32'd0) begin bad++; $display("FAIL pass_d_data got=%h exp=0", d_data); end
        total++; if ({test_done, test_pass, test_code} !== {1'b1, 1'b1, 16'h0}) begin bad++; $display("FAIL pass_ind got=%b%b%h exp=1 1 0000", test_done, test_pass, test_code); end
        pop();
        send(3'd4, 15'h000, 32'h0, 4'hF, 2'd2, 1'b0);
        total++; if ({d_opcode, d_data, d_denied, d_corrupt} !== {3'd1, 32'h5555, 1'b0, 1'b0}) begin bad++; $display("FAIL pass_get_status got op=%0d data=%h den=%b cor=%b exp op=1 data=00005555", d_opcode, d_data, d_denied, d_corrupt); end
        pop();
        total++; if (d_valid !== 1'b0) begin bad++; $display("FAIL pass_drained got=%b exp=0", d_valid); end
    endtask

    task automatic test_fail_write;
        do_reset();
        send(3'd1, 15'h000, 32'h002A_3333, 4'hF, 2'd0, 1'b0);
        total++; if ({test_done, test_pass, test_code} !== {1'b1, 1'b0, 16'h002A}) begin bad++; $display("FAIL fail_ind got=%b%b%h exp=1 0 002a", test_done, test_pass, test_code); end
        pop();
        send(3'd0, 15'h000, 32'h0000_5555, 4'hF, 2'd0, 1'b0);
        pop();
        total++; if ({test_done, test_pass, test_code} !== {1'b1, 1'b0, 16'h002A}) begin bad++; $display("FAIL fail_sticky got=%b%b%h exp=1 0 002a", test_done, test_pass, test_code); end
        send(3'd1, 15'h000, 32'hAABB_CCDD, 4'b0101, 2'd0, 1'b0);
        pop();
        send(3'd4, 15'h000, 32'h0, 4'hF, 2'd3, 1'b0);
        total++; if (d_data !== 32'h00BB_55DD) begin bad++; $display("FAIL fail_mask_merge got=%h exp=00bb55dd", d_data); end
        total++; if (d_source !== 2'd3) begin bad++; $display("FAIL fail_src_echo got=%0d exp=3", d_source); end
        pop();
    endtask

    task automatic test_back_to_back;
        d_ready = 0;
        send(3'd4, 15'h000, 32'h0, 4'hF, 2'd1, 1'b0);
        send(3'd4, 15'h000, 32'h0, 4'hF, 2'd2, 1'b0);
        total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL b2b_full_a_ready got=%b exp=0", a_ready); end
        total++; if ({d_valid, d_source, d_data} !== {1'b1, 2'd1, 32'h00BB_55DD}) begin bad++; $display("FAIL b2b_head got v=%b src=%0d data=%h exp v=1 src=1 data=00bb55dd", d_valid, d_source, d_data); end
        @(negedge clock);
        a_valid = 1; a_opcode = 3'd4; a_address = 15'h000; a_source = 2'd3; a_corrupt = 0;
        @(posedge clock);
        @(negedge clock);
        total++; if ({a_ready, d_source} !== {1'b0, 2'd1}) begin bad++; $display("FAIL b2b_blocked got rdy=%b src=%0d exp rdy=0 src=1", a_ready, d_source); end
        d_ready = 1;
        @(negedge clock);
        total++; if ({a_ready, d_valid, d_source} !== {1'b1, 1'b1, 2'd2}) begin bad++; $display("FAIL b2b_second got rdy=%b v=%b src=%0d exp rdy=1 v=1 src=2", a_ready, d_valid, d_source); end
        @(negedge clock);
        total++; if ({d_valid, d_source} !== {1'b1, 2'd3}) begin bad++; $display("FAIL b2b_third got v=%b src=%0d exp v=1 src=3", d_valid, d_source); end
        a_valid = 0;
        @(negedge clock);
        total++; if (d_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b exp=0", d_valid); end
        d_ready = 0;
    endtask

    task automatic test_denied;
        do_reset();
        send(3'd4, 15'h008, 32'h0, 4'hF, 2'd1, 1'b0);
        total++; if ({d_opcode, d_denied, d_corrupt, d_data} !== {3'd1, 1'b1, 1'b1, 32'd0}) begin bad++; $display("FAIL den_get_bad_addr got op=%0d den=%b cor=%b data=%h exp op=1 den=1 cor=1 data=0", d_opcode, d_denied, d_corrupt, d_data); end
        pop();
        send(3'd0, 15'h004, 32'h0000_5555, 4'hF, 2'd2, 1'b0);
        total++; if ({d_opcode, d_denied, d_corrupt} !== {3'd0, 1'b1, 1'b0}) begin bad++; $display("FAIL den_put_cycles got op=%0d den=%b cor=%b exp op=0 den=1 cor=0", d_opcode, d_denied, d_corrupt); end
        pop();
        send(3'd2, 15'h000, 32'h0000_5555, 4'hF, 2'd3, 1'b0);
        total++; if ({d_opcode, d_denied, d_corrupt} !== {3'd0, 1'b1, 1'b0}) begin bad++; $display("FAIL den_bad_opcode got op=%0d den=%b cor=%b exp op=0 den=1 cor=0", d_opcode, d_denied, d_corrupt); end
        pop();
        send(3'd0, 15'h000, 32'h0000_5555, 4'hF, 2'd0, 1'b1);
        total++; if ({d_opcode, d_denied, d_corrupt} !== {3'd0, 1'b1, 1'b0}) begin bad++; $display("FAIL den_corrupt_put got op=%0d den=%b cor=%b exp op=0 den=1 cor=0", d_opcode, d_denied, d_corrupt); end
        pop();
        send(3'd4, 15'h000, 32'h0, 4'hF, 2'd0, 1'b0);
        total++; if ({d_data, d_denied} !== {32'd0, 1'b0}) begin bad++; $display("FAIL den_status_unchanged got data=%h den=%b exp data=0 den=0", d_data, d_denied); end
        total++; if ({test_done, test_pass, test_code} !== 18'd0) begin bad++; $display("FAIL den_ind_unchanged got=%b%b%h exp=0", test_done, test_pass, test_code); end
        pop();
    endtask

    task automatic test_cycles_and_reset;
        send(3'd4, 15'h004, 32'h0, 4'hF, 2'd0, 1'b0);
        v1 = d_data;
        total++; if ({d_opcode, d_denied} !== {3'd1, 1'b0}) begin bad++; $display("FAIL cyc_get1 got op=%0d den=%b exp op=1 den=0", d_opcode, d_denied); end
        pop();
        repeat (8) @(posedge clock);
        send(3'd4, 15'h004, 32'h0, 4'hF, 2'd0, 1'b0);
        v2 = d_data;
        total++; if (v2 - v1 !== 32'd10) begin bad++; $display("FAIL cyc_delta got=%0d exp=10", v2 - v1); end
        pop();
        send(3'd4, 15'h000, 32'h0, 4'hF, 2'd1, 1'b0);
        send(3'd4, 15'h000, 32'h0, 4'hF, 2'd2, 1'b0);
        total++; if ({d_valid, a_ready} !== 2'b10) begin bad++; $display("FAIL rstq_queued got v=%b rdy=%b exp v=1 rdy=0", d_valid, a_ready); end
        @(negedge clock);
        reset = 1;
        @(posedge clock);
        #1;
        total++; if ({d_valid, a_ready, d_source, d_data} !== 36'd0) begin bad++; $display("FAIL rstq_in_reset got v=%b rdy=%b src=%0d data=%h exp all 0", d_valid, a_ready, d_source, d_data); end
        @(negedge clock);
        reset = 0;
        @(posedge clock);
        #1;
        total++; if ({d_valid, a_ready} !== 2'b01) begin bad++; $display("FAIL rstq_after got v=%b rdy=%b exp v=0 rdy=1", d_valid, a_ready); end
    endtask

    initial begin
        test_reset();
        test_pass_write();
        test_fail_write();
        test_back_to_back();
        test_denied();
        test_cycles_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
